mxu_feed_sequencer: RTL and testbench
=====================================

Name: mxu_feed_sequencer

Overview:
Controller that owns the operand staging buffers for the GRID_SIZE x GRID_SIZE systolic mxu and sequences one matrix-multiply pass. A host loads west operands (rows of A) and north operands (columns of B) through a write port, then issues start. The block clears the array, drives skewed, zero-padded lane data with ce for an exact cycle count, and reports done. It replaces free-running index counters with bounded, wrap-free sequencing.

Parameters:
NUM_SIZE, 16, operand/lane width in bits
GRID_SIZE, 2, array dimension (lanes per edge)
BUFFER_LEN, 8, max reduction depth K (entries per lane buffer)
ADDRESS_LEN, 3, clog2(BUFFER_LEN), buffer address width
KLEN_W, 4, width of k_len, holds 0..BUFFER_LEN

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
wr_en  in  1  buffer write strobe
wr_sel  in  1  0 = west buffer, 1 = north buffer
wr_lane  in  clog2(GRID_SIZE)  lane index
wr_addr  in  ADDRESS_LEN  entry index k
wr_data  in  NUM_SIZE  operand
start  in  1  begin pass, sampled in IDLE
k_len  in  KLEN_W  reduction depth, sampled with start
busy  out  1  high in CLEAR/RUN/DONE
done  out  1  one-cycle pulse at end of pass
err  out  1  one-cycle pulse on rejected write or start
mxu_clear  out  1  one-cycle accumulator clear to mxu rst
mxu_ce  out  1  mxu clock enable
north_input  out  NUM_SIZE*GRID_SIZE  lane j at bits [(j+1)*NUM_SIZE-1 : j*NUM_SIZE]
west_input  out  NUM_SIZE*GRID_SIZE  same packing

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state updates occur on posedge clk.
- Reset: state=IDLE, busy=0, done=0, err=0, mxu_clear=0, mxu_ce=0, north_input=0, west_input=0, cycle counter=0, k_reg=0. Buffer contents are not reset.
- States: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
- IDLE: wr_en writes buffer[wr_sel][wr_lane][wr_addr] <= wr_data, visible from the next cycle. If start=1 and 1<=k_len<=BUFFER_LEN, latch k_reg=k_len, go to CLEAR. If start=1 with k_len=0 or k_len>BUFFER_LEN, pulse err and stay in IDLE. If wr_en and start are both high, the write completes and the pass uses the new data.
- CLEAR: lasts exactly one cycle. mxu_clear=1, mxu_ce=0, lanes=0. Then go to RUN with t=0.
- RUN: mxu_ce=1 every cycle, for exactly N_RUN = k_reg + 2*(GRID_SIZE-1) + 1 cycles (t = 0..N_RUN-1). At cycle t, lane i of west_input = west_buf[i][t-i] if 0 <= t-i < k_reg, else 0. north_input is the same using north_buf. Lane data is registered, so the value for cycle t is presented during the cycle mxu_ce is high for t. Addresses never wrap; out-of-range reads yield zero. The trailing +1 cycle drains the PE output register. After t=N_RUN-1, go to DONE.
- DONE: lasts one cycle. done=1, mxu_ce=0, lanes=0, then go to IDLE. mxu results are valid from the DONE cycle and hold while mxu_ce=0.
- While busy: wr_en is ignored, the buffer is unchanged, and err pulses. start is ignored with no err.
- rst asserted mid-pass: next cycle is IDLE with all outputs at reset values. The mxu is not cleared until the next CLEAR.
- Counter t is ADDRESS_LEN+2 bits wide, enough for BUFFER_LEN + 2*GRID_SIZE. Lane index arithmetic is signed or guarded so that t<i never aliases.

Decomposition:
- Shared package mxu_pkg holds NUM_SIZE, GRID_SIZE, BUFFER_LEN, ADDRESS_LEN, a state enum {IDLE, CLEAR, RUN, DONE}, and a lane_t typedef of logic [NUM_SIZE-1:0]. It is reused by mxu and the top level.
- One sub-module, mxu_lane_buffer: a single lane's BUFFER_LEN x NUM_SIZE storage with a write port and a guarded read (zero when out of range). It is instantiated 2*GRID_SIZE times. The FSM and counter stay in the top.

Test Plan:
- Basic 2x2 multiply: write A=[[1,2],[3,4]] as west_buf[i][k]=A[i][k] and B=[[5,6],[7,8]] as north_buf[j][k]=B[k][j]; start with k_len=2 -> mxu_clear for 1 cycle, mxu_ce high for exactly 5 cycles, done pulses on the next cycle, mxu results = 19, 22, 43, 50.
- Skew check with k_len=2: during RUN, west lane0 reads 1,2,0,0,0 and west lane1 reads 0,3,4,0,0; north lanes follow the same pattern.
- Bad start: start with k_len=0 -> err pulses once, busy stays 0, mxu_ce never rises. Repeat with k_len=9 and get the same result.
- Write while busy: wr_en during RUN to west lane0 addr0 with data 99 -> err pulses, and a second pass with k_len=2 still yields 19, 22, 43, 50.
- Full depth: k_len=8 with all operands 1 -> mxu_ce high for 11 cycles, every result = 8.
- Reset mid-RUN at t=2 -> next cycle busy=0, mxu_ce=0, lanes=0, no done pulse. A fresh start then completes normally with correct results.

Source files
------------

// File: rtl/mxu_pkg.sv
// Shared parameters and types for the mxu array and its feed sequencer.
// Lane width, grid size and buffer depth live here so every user agrees.
package mxu_pkg;

  localparam int NUM_SIZE    = 16;
  localparam int GRID_SIZE   = 2;
  localparam int BUFFER_LEN  = 8;
  localparam int ADDRESS_LEN = 3;
  localparam int KLEN_W      = 4;
  localparam int LANE_W      = $clog2(GRID_SIZE);
  localparam int CNT_W       = ADDRESS_LEN + 2;
  localparam int POS_W       = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_e;

  typedef logic [NUM_SIZE-1:0] lane_t;

  // Run length: K products plus skew fill/drain plus one output-register cycle.
  function automatic logic [CNT_W-1:0] n_run(
    input logic [KLEN_W-1:0] k
  );
    return CNT_W'(k) + CNT_W'(2 * (GRID_SIZE - 1) + 1);
  endfunction

endpackage

// File: rtl/mxu_lane_buffer.sv
// One operand lane: BUFFER_LEN entries, write port and a guarded read
// that returns zero for negative positions or positions past rd_len.
module mxu_lane_buffer
  import mxu_pkg::*;
(
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDRESS_LEN-1:0]  wr_addr,
  input  lane_t                   wr_data,
  input  logic signed [POS_W-1:0] rd_pos,
  input  logic [KLEN_W-1:0]       rd_len,
  output lane_t                   rd_data
);

  lane_t mem_q [BUFFER_LEN];
  logic  in_range;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign in_range = !rd_pos[POS_W-1]
    && ({1'b0, rd_pos[POS_W-2:0]} < POS_W'(rd_len))
    && (rd_pos[POS_W-2:0] < (POS_W-1)'(BUFFER_LEN));

  assign rd_data = in_range ? mem_q[rd_pos[ADDRESS_LEN-1:0]] : '0;

endmodule

// File: rtl/mxu_feed_sequencer.sv
// Owns the west/north operand buffers and sequences one skewed
// matrix-multiply pass into the systolic mxu: CLEAR, RUN, DONE.
module mxu_feed_sequencer
  import mxu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [LANE_W-1:0]             wr_lane,
  input  logic [ADDRESS_LEN-1:0]        wr_addr,
  input  logic [NUM_SIZE-1:0]           wr_data,
  input  logic                          start,
  input  logic [KLEN_W-1:0]             k_len,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          mxu_clear,
  output logic                          mxu_ce,
  output logic [NUM_SIZE*GRID_SIZE-1:0] north_input,
  output logic [NUM_SIZE*GRID_SIZE-1:0] west_input
);

  state_e                        state_q;
  logic [CNT_W-1:0]              t_q;
  logic [KLEN_W-1:0]             k_q;
  logic                          done_q;
  logic                          err_q;
  logic                          clr_q;
  logic                          ce_q;
  logic [NUM_SIZE*GRID_SIZE-1:0] west_q;
  logic [NUM_SIZE*GRID_SIZE-1:0] north_q;

  logic [CNT_W-1:0]              rd_t;
  logic [CNT_W-1:0]              last_t;
  logic                          k_ok;
  logic [NUM_SIZE*GRID_SIZE-1:0] west_pk;
  logic [NUM_SIZE*GRID_SIZE-1:0] north_pk;

  // Lanes are registered, so read one step ahead of the presented t.
  assign rd_t   = (state_q == RUN) ? t_q + CNT_W'(1) : '0;
  assign last_t = n_run(k_q) - CNT_W'(1);
  assign k_ok   = (k_len != '0) && (k_len <= KLEN_W'(BUFFER_LEN));

  for (genvar g = 0; g < GRID_SIZE; g++) begin : g_lane
    logic signed [POS_W-1:0] pos;
    logic                    wr_lane_hit;
    lane_t                   west_rd;
    lane_t                   north_rd;

    assign pos = $signed({1'b0, rd_t}) - $signed(POS_W'(g));
    assign wr_lane_hit = wr_en && (state_q == IDLE)
      && (wr_lane == LANE_W'(g));

    mxu_lane_buffer u_west (
      .clk     (clk),
      .wr_en   (wr_lane_hit && !wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_pos  (pos),
      .rd_len  (k_q),
      .rd_data (west_rd)
    );

    mxu_lane_buffer u_north (
      .clk     (clk),
      .wr_en   (wr_lane_hit && wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_pos  (pos),
      .rd_len  (k_q),
      .rd_data (north_rd)
    );

    assign west_pk[g*NUM_SIZE +: NUM_SIZE]  = west_rd;
    assign north_pk[g*NUM_SIZE +: NUM_SIZE] = north_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      ce_q    <= 1'b0;
      west_q  <= '0;
      north_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      clr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && k_ok) begin
            k_q     <= k_len;
            clr_q   <= 1'b1;
            state_q <= CLEAR;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= RUN;
          t_q     <= '0;
          ce_q    <= 1'b1;
          west_q  <= west_pk;
          north_q <= north_pk;
        end
        RUN: begin
          if (t_q == last_t) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ce_q    <= 1'b0;
            west_q  <= '0;
            north_q <= '0;
          end else begin
            t_q     <= t_q + CNT_W'(1);
            west_q  <= west_pk;
            north_q <= north_pk;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (wr_en && (state_q != IDLE)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign mxu_clear   = clr_q;
  assign mxu_ce      = ce_q;
  assign west_input  = west_q;
  assign north_input = north_q;

endmodule

// File: tb/tb_mxu_feed_sequencer.sv
// Bench for mxu_feed_sequencer: vector tables, directed corner passes and
// random passes scored by a consumer-side systolic array model.
module tb_mxu_feed_sequencer;

  localparam int G  = 2;
  localparam int KM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [0:0]  wr_lane = '0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic [3:0]  k_len = '0;
  logic        busy, done, err, mxu_clear, mxu_ce;
  logic [31:0] north_input, west_input;

  mxu_feed_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_lane     (wr_lane),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mxu_clear   (mxu_clear),
    .mxu_ce      (mxu_ce),
    .north_input (north_input),
    .west_input  (west_input)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   k;
    logic exp_err;
  } bad_t;

  typedef struct {
    int w0;
    int w1;
    int n0;
    int n1;
  } skew_t;

  int errors = 0;
  int checks = 0;
  int mb [2][G][KM];
  int wh [G][64];
  int nh [G][64];
  int nce, ndone, nclr;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int sel, input int lane, input int addr,
                    input int data);
    wr_en   = 1'b1;
    wr_sel  = sel[0];
    wr_lane = lane[0];
    wr_addr = addr[2:0];
    wr_data = data[15:0];
    @(negedge clk);
    wr_en = 1'b0;
    mb[sel][lane][addr] = data & 16'hffff;
  endtask

  // Ideal result: plain matrix product over the first k entries.
  function automatic int ref_c(input int i, input int j, input int k);
    int s = 0;
    for (int kk = 0; kk < k; kk++) s += mb[0][i][kk] * mb[1][j][kk];
    return s;
  endfunction

  // Output-stationary array: PE(i,j) sees west lane i delayed j and
  // north lane j delayed i, multiplying only while ce was high.
  function automatic int got_c(input int i, input int j);
    int s = 0;
    for (int t = 0; t < nce; t++)
      if (t - j >= 0 && t - i >= 0) s += wh[i][t-j] * nh[j][t-i];
    return s;
  endfunction

  task automatic run_pass(input int k, input int wr_at, input int rst_at);
    bit fired = 0;
    start = 1'b1;
    k_len = k[3:0];
    @(negedge clk);
    start = 1'b0;
    check("clear_cycle", {29'd0, mxu_clear, mxu_ce, busy}, 32'd5);
    nce = 0;
    ndone = 0;
    nclr = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (wr_en) begin
        wr_en = 1'b0;
        check("busy_write_err", {31'd0, err}, 32'd1);
      end
      if (mxu_clear) nclr++;
      if (mxu_ce) begin
        wh[0][nce] = int'(west_input[15:0]);
        wh[1][nce] = int'(west_input[31:16]);
        nh[0][nce] = int'(north_input[15:0]);
        nh[1][nce] = int'(north_input[31:16]);
        nce++;
      end
      if (done) begin
        ndone++;
        check("done_state", {28'd0, busy, mxu_ce, |west_input,
              |north_input}, 32'd8);
        break;
      end
      if (rst_at >= 0 && nce == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_run", {25'd0, busy, done, mxu_ce, mxu_clear, err,
              |west_input, |north_input}, 32'd0);
        fired = 1;
        break;
      end
      if (wr_at >= 0 && nce == wr_at && !fired) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_lane = 1'b0;
        wr_addr = 3'd0;
        wr_data = 16'd99;
        fired   = 1;
      end
    end
    if (rst_at < 0) begin
      check("done_seen", ndone, 1);
      check("ce_cycles", nce, k + 2 * (G - 1) + 1);
      check("clear_in_run", nclr, 0);
      @(negedge clk);
      check("idle_after", {30'd0, busy, done}, 32'd0);
    end else begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done || busy || mxu_ce) ndone++;
      end
      check("quiet_after_rst", ndone, 0);
    end
  endtask

  task automatic check_pass(input int k);
    int bad = 0;
    for (int t = 0; t < nce; t++)
      for (int i = 0; i < G; i++) begin
        int e_w = (t - i >= 0 && t - i < k) ? mb[0][i][t-i] : 0;
        int e_n = (t - i >= 0 && t - i < k) ? mb[1][i][t-i] : 0;
        if (wh[i][t] != e_w || nh[i][t] != e_n) bad++;
      end
    check("lane_streams", bad, 0);
    for (int i = 0; i < G; i++)
      for (int j = 0; j < G; j++)
        check("result", got_c(i, j), ref_c(i, j, k));
  endtask

  task automatic load_basic();
    int a [2][2];
    int b [2][2];
    a = '{'{1, 2}, '{3, 4}};
    b = '{'{5, 6}, '{7, 8}};
    for (int i = 0; i < 2; i++)
      for (int kk = 0; kk < 2; kk++) begin
        wr(0, i, kk, a[i][kk]);
        wr(1, i, kk, b[kk][i]);
      end
  endtask

  task automatic check_basic(input string tag);
    int exp_c [4];
    exp_c = '{19, 22, 43, 50};
    for (int n = 0; n < 4; n++)
      check(tag, got_c(n / 2, n % 2), exp_c[n]);
  endtask

  bad_t  bad_tab [3];
  skew_t skew_tab [5];

  initial begin
    bad_tab[0] = '{k: 0, exp_err: 1'b1};
    bad_tab[1] = '{k: 9, exp_err: 1'b1};
    bad_tab[2] = '{k: 15, exp_err: 1'b1};
    skew_tab[0] = '{w0: 1, w1: 0, n0: 5, n1: 0};
    skew_tab[1] = '{w0: 2, w1: 3, n0: 7, n1: 6};
    skew_tab[2] = '{w0: 0, w1: 4, n0: 0, n1: 8};
    skew_tab[3] = '{w0: 0, w1: 0, n0: 0, n1: 0};
    skew_tab[4] = '{w0: 0, w1: 0, n0: 0, n1: 0};

    repeat (3) @(negedge clk);
    check("reset_state", {25'd0, busy, done, err, mxu_clear, mxu_ce,
          |west_input, |north_input}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 3; n++) begin
      start = 1'b1;
      k_len = bad_tab[n].k[3:0];
      @(negedge clk);
      start = 1'b0;
      check("bad_start_err", {31'd0, err}, {31'd0, bad_tab[n].exp_err});
      check("bad_start_idle", {30'd0, busy, mxu_ce}, 32'd0);
      @(negedge clk);
      check("bad_err_pulse", {29'd0, err, busy, mxu_ce}, 32'd0);
    end

    load_basic();
    run_pass(2, -1, -1);
    for (int t = 0; t < 5; t++) begin
      check("skew_w0", wh[0][t], skew_tab[t].w0);
      check("skew_w1", wh[1][t], skew_tab[t].w1);
      check("skew_n0", nh[0][t], skew_tab[t].n0);
      check("skew_n1", nh[1][t], skew_tab[t].n1);
    end
    check_basic("basic_result");

    run_pass(2, 2, -1);
    check_basic("busy_write_pass");
    run_pass(2, -1, -1);
    check_basic("after_busy_write");

    run_pass(2, -1, 3);
    run_pass(2, -1, -1);
    check_basic("after_mid_reset");

    for (int i = 0; i < G; i++)
      for (int kk = 0; kk < KM; kk++) begin
        wr(0, i, kk, 1);
        wr(1, i, kk, 1);
      end
    run_pass(8, -1, -1);
    for (int n = 0; n < 4; n++)
      check("full_depth", got_c(n / 2, n % 2), 8);

    for (int r = 0; r < 15; r++) begin
      int k = $urandom_range(1, KM);
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < G; i++)
          for (int kk = 0; kk < KM; kk++)
            wr(s, i, kk, $urandom_range(0, 1000));
      run_pass(k, -1, -1);
      check_pass(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
